// File: rtl/wb_stage_if.sv
// Memory-stage handshake, data-memory response, register-file write port,
// forwarding path and status outputs of the writeback stage.
interface wb_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 64
);
  logic             in_valid;
  logic             in_ready;
  logic             in_reg_write;
  logic [4:0]       in_rd;
  logic [1:0]       in_wb_sel;
  logic [XLEN-1:0]  in_alu_result;
  logic [XLEN-1:0]  in_pc_plus4;
  logic [2:0]       in_funct3;
  logic             dmem_rvalid;
  logic [XLEN-1:0]  dmem_rdata;
  logic             rf_we;
  logic [4:0]       rf_rd;
  logic [XLEN-1:0]  rf_wd;
  logic             fwd_valid;
  logic [4:0]       fwd_rd;
  logic [XLEN-1:0]  fwd_data;
  logic             ld_err;
  logic [CNT_W-1:0] instret;

  // Stage side.
  modport slave (
    input  in_valid, in_reg_write, in_rd, in_wb_sel, in_alu_result, in_pc_plus4, in_funct3,
    input  dmem_rvalid, dmem_rdata,
    output in_ready, rf_we, rf_rd, rf_wd, fwd_valid, fwd_rd, fwd_data, ld_err, instret
  );

  // Environment side (memory stage, data memory, register file).
  modport master (
    output in_valid, in_reg_write, in_rd, in_wb_sel, in_alu_result, in_pc_plus4, in_funct3,
    output dmem_rvalid, dmem_rdata,
    input  in_ready, rf_we, rf_rd, rf_wd, fwd_valid, fwd_rd, fwd_data, ld_err, instret
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: selects ALU / load / PC+4 result, drives a registered
// register-file write port plus identical forwarding path, counts retirements.
// Loads park in StWaitLd until the data-memory response is sampled.
module wb_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 64
) (
  input logic        clk,
  input logic        rst_n,
  wb_stage_if.slave  bus
);

  localparam logic StIdle   = 1'b0;
  localparam logic StWaitLd = 1'b1;

  logic             state_q, state_d;
  logic             pend_rw_q, pend_rw_d;
  logic [4:0]       pend_rd_q, pend_rd_d;
  logic [2:0]       pend_f3_q, pend_f3_d;
  logic [1:0]       pend_off_q, pend_off_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]  rf_wd_q, rf_wd_d;
  logic             ld_err_q, ld_err_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic             ld_legal;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [XLEN-1:0]  ld_data;
  logic             wr_en;

  // Load legality from funct3 and the address offset of the incoming instruction.
  always_comb begin
    unique case (bus.in_funct3)
      3'b000, 3'b100: ld_legal = 1'b1;
      3'b001, 3'b101: ld_legal = ~bus.in_alu_result[0];
      3'b010:         ld_legal = (bus.in_alu_result[1:0] == 2'b00);
      default:        ld_legal = 1'b0;
    endcase
  end

  // Align and extend the response word using the latched funct3/offset.
  always_comb begin
    ld_byte = bus.dmem_rdata[{pend_off_q, 3'b000} +: 8];
    ld_half = bus.dmem_rdata[{pend_off_q[1], 4'b0000} +: 16];
    unique case (pend_f3_q[1:0])
      2'b00:   ld_data = {{(XLEN-8){ld_byte[7] & ~pend_f3_q[2]}}, ld_byte};
      2'b01:   ld_data = {{(XLEN-16){ld_half[15] & ~pend_f3_q[2]}}, ld_half};
      default: ld_data = bus.dmem_rdata;
    endcase
  end

  // Next-state: accept in StIdle, complete loads in StWaitLd.
  always_comb begin
    state_d    = state_q;
    pend_rw_d  = pend_rw_q;
    pend_rd_d  = pend_rd_q;
    pend_f3_d  = pend_f3_q;
    pend_off_d = pend_off_q;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wd_d    = rf_wd_q;
    ld_err_d   = 1'b0;
    instret_d  = instret_q;
    wr_en      = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          if (bus.in_wb_sel == 2'b01) begin
            if (!ld_legal) begin
              ld_err_d = 1'b1;
            end else begin
              pend_rw_d  = bus.in_reg_write;
              pend_rd_d  = bus.in_rd;
              pend_f3_d  = bus.in_funct3;
              pend_off_d = bus.in_alu_result[1:0];
              state_d    = StWaitLd;
            end
          end else begin
            wr_en     = bus.in_reg_write && (bus.in_rd != 5'd0);
            rf_we_d   = wr_en;
            instret_d = instret_q + CNT_W'(1);
            // rd/wd only move with a real write so they hold otherwise.
            if (wr_en) begin
              rf_rd_d = bus.in_rd;
              rf_wd_d = (bus.in_wb_sel == 2'b10) ? bus.in_pc_plus4 : bus.in_alu_result;
            end
          end
        end
      end
      StWaitLd: begin
        if (bus.dmem_rvalid) begin
          wr_en     = pend_rw_q && (pend_rd_q != 5'd0);
          rf_we_d   = wr_en;
          instret_d = instret_q + CNT_W'(1);
          state_d   = StIdle;
          if (wr_en) begin
            rf_rd_d = pend_rd_q;
            rf_wd_d = ld_data;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset drops any pending load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pend_rw_q  <= 1'b0;
      pend_rd_q  <= 5'd0;
      pend_f3_q  <= 3'd0;
      pend_off_q <= 2'd0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= 5'd0;
      rf_wd_q    <= '0;
      ld_err_q   <= 1'b0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      pend_rw_q  <= pend_rw_d;
      pend_rd_q  <= pend_rd_d;
      pend_f3_q  <= pend_f3_d;
      pend_off_q <= pend_off_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wd_q    <= rf_wd_d;
      ld_err_q   <= ld_err_d;
      instret_q  <= instret_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_rd     = rf_rd_q;
  assign bus.rf_wd     = rf_wd_q;
  assign bus.fwd_valid = rf_we_q;
  assign bus.fwd_rd    = rf_rd_q;
  assign bus.fwd_data  = rf_wd_q;
  assign bus.ld_err    = ld_err_q;
  assign bus.instret   = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: table of instructions driven through the handshake,
// expected completions queued at accept and checked when the stage retires.
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_stage_if #(.XLEN(32), .CNT_W(64)) bus ();

  wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] rdata;
    int          dly;
    logic        exp_err;
    logic        exp_we;
    logic [31:0] exp_wd;
  } vec_t;

  typedef struct {
    logic        err;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [63:0] cnt;
  } exp_t;

  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        q[$];
  logic [63:0] exp_cnt = 64'd0;
  logic [63:0] prev_cnt = 64'd0;
  logic        mon_en = 1'b0;
  vec_t        vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] sel, input logic [2:0] f3, input logic [4:0] rd,
                              input logic rw, input logic [31:0] alu, input logic [31:0] pc4,
                              input logic [31:0] rdata, input int dly, input logic err,
                              input logic we, input logic [31:0] wd);
    vec_t v;
    v.sel = sel; v.f3 = f3; v.rd = rd; v.rw = rw; v.alu = alu; v.pc4 = pc4;
    v.rdata = rdata; v.dly = dly; v.exp_err = err; v.exp_we = we; v.exp_wd = wd;
    return v;
  endfunction

  // Completion monitor: a retirement shows up as an instret step or an ld_err pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cnt = bus.instret;
    end else if (mon_en) begin
      if ((bus.instret != prev_cnt) || bus.ld_err) begin
        if (q.size() == 0) begin
          chk("unexpected_completion", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("ld_err", bus.ld_err, e.err);
          if (e.err) begin
            chk("we_on_err", bus.rf_we, 1'b0);
            chk("instret_on_err", bus.instret, prev_cnt);
          end else begin
            chk("rf_we", bus.rf_we, e.we);
            chk("instret", bus.instret, e.cnt);
            if (e.we) begin
              chk("rf_rd", bus.rf_rd, e.rd);
              chk("rf_wd", bus.rf_wd, e.wd);
              chk("fwd_valid", bus.fwd_valid, 1'b1);
              chk("fwd_rd", bus.fwd_rd, e.rd);
              chk("fwd_data", bus.fwd_data, e.wd);
              chk("ready_in_write_cycle", bus.in_ready, 1'b1);
            end
          end
        end
      end else begin
        chk("idle_we", bus.rf_we, 1'b0);
        chk("idle_fwd_valid", bus.fwd_valid, 1'b0);
      end
      prev_cnt = bus.instret;
    end
  end

  // Issue one instruction (called at posedge+1); serves the load response when needed.
  task automatic send(input vec_t v);
    exp_t e;
    int   w;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk("ready_before_accept", bus.in_ready, 1'b1);
    bus.in_valid      = 1'b1;
    bus.in_wb_sel     = v.sel;
    bus.in_funct3     = v.f3;
    bus.in_rd         = v.rd;
    bus.in_reg_write  = v.rw;
    bus.in_alu_result = v.alu;
    bus.in_pc_plus4   = v.pc4;
    e.err = v.exp_err;
    e.we  = v.exp_we;
    e.rd  = v.rd;
    e.wd  = v.exp_wd;
    if (!v.exp_err) exp_cnt = exp_cnt + 64'd1;
    e.cnt = exp_cnt;
    q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid      = 1'b0;
    bus.in_alu_result = $urandom;
    bus.in_rd         = 5'($urandom);
    if (v.sel == 2'b01 && !v.exp_err) begin
      for (int i = 1; i < v.dly; i++) begin
        chk("ready_low_wait", bus.in_ready, 1'b0);
        bus.dmem_rdata = $urandom;
        @(posedge clk); #1;
      end
      chk("ready_low_resp", bus.in_ready, 1'b0);
      bus.dmem_rdata  = v.rdata;
      bus.dmem_rvalid = 1'b1;
      @(posedge clk); #1;
      bus.dmem_rvalid = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_reg_write = 1'b0; bus.in_rd = 5'd0; bus.in_wb_sel = 2'b00;
    bus.in_alu_result = 32'd0; bus.in_pc_plus4 = 32'd0; bus.in_funct3 = 3'd0;
    bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'd0;

    //          sel    f3      rd     rw    alu           pc4           rdata        dly err  we   wd
    vecs[0]  = mk(2'b00, 3'b000, 5'd5,  1'b1, 32'h0000_1234, 32'h0,        32'h0,       0, 1'b0, 1'b1, 32'h0000_1234);
    vecs[1]  = mk(2'b01, 3'b000, 5'd6,  1'b1, 32'h0000_1003, 32'h0,        32'h80FF_0102, 3, 1'b0, 1'b1, 32'hFFFF_FF80);
    vecs[2]  = mk(2'b01, 3'b101, 5'd7,  1'b1, 32'h0000_2002, 32'h0,        32'h8001_0000, 1, 1'b0, 1'b1, 32'h0000_8001);
    vecs[3]  = mk(2'b01, 3'b001, 5'd8,  1'b1, 32'h0000_2002, 32'h0,        32'h8001_0000, 2, 1'b0, 1'b1, 32'hFFFF_8001);
    vecs[4]  = mk(2'b01, 3'b010, 5'd9,  1'b1, 32'h0000_3000, 32'h0,        32'hDEAD_BEEF, 1, 1'b0, 1'b1, 32'hDEAD_BEEF);
    vecs[5]  = mk(2'b01, 3'b010, 5'd10, 1'b1, 32'h0000_3002, 32'h0,        32'h0,       0, 1'b1, 1'b0, 32'h0);
    vecs[6]  = mk(2'b01, 3'b110, 5'd11, 1'b1, 32'h0000_3000, 32'h0,        32'h0,       0, 1'b1, 1'b0, 32'h0);
    vecs[7]  = mk(2'b10, 3'b000, 5'd0,  1'b1, 32'h0000_0055, 32'h0000_0100, 32'h0,      0, 1'b0, 1'b0, 32'h0);
    vecs[8]  = mk(2'b00, 3'b000, 5'd1,  1'b1, 32'h0000_A5A5, 32'h0000_0999, 32'h0,      0, 1'b0, 1'b1, 32'h0000_A5A5);
    vecs[9]  = mk(2'b01, 3'b100, 5'd12, 1'b1, 32'h0000_4001, 32'h0,        32'h1234_80FF, 1, 1'b0, 1'b1, 32'h0000_0080);
    vecs[10] = mk(2'b11, 3'b000, 5'd13, 1'b1, 32'h0000_0077, 32'h0000_0999, 32'h0,      0, 1'b0, 1'b1, 32'h0000_0077);
    vecs[11] = mk(2'b00, 3'b000, 5'd14, 1'b0, 32'h0000_0123, 32'h0,        32'h0,       0, 1'b0, 1'b0, 32'h0);
    vecs[12] = mk(2'b01, 3'b001, 5'd15, 1'b1, 32'h0000_5001, 32'h0,        32'h0,       0, 1'b1, 1'b0, 32'h0);
    vecs[13] = mk(2'b01, 3'b000, 5'd16, 1'b1, 32'h0000_6000, 32'h0,        32'h0000_007F, 4, 1'b0, 1'b1, 32'h0000_007F);
    vecs[14] = mk(2'b10, 3'b000, 5'd31, 1'b1, 32'h0000_0001, 32'h0000_2000, 32'h0,      0, 1'b0, 1'b1, 32'h0000_2000);

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.in_ready, 1'b1);
    chk("rst_we", bus.rf_we, 1'b0);
    chk("rst_rd", bus.rf_rd, 5'd0);
    chk("rst_wd", bus.rf_wd, 32'd0);
    chk("rst_fwd", {bus.fwd_valid, bus.fwd_rd, bus.fwd_data}, 64'd0);
    chk("rst_ld_err", bus.ld_err, 1'b0);
    chk("rst_instret", bus.instret, 64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Table, issued back-to-back (loads overlap the next accept with their write).
    foreach (vecs[i]) send(vecs[i]);
    repeat (3) @(posedge clk);
    #1;

    // Response strobe while idle must be ignored.
    bus.dmem_rdata  = 32'hFFFF_FFFF;
    bus.dmem_rvalid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.dmem_rvalid = 1'b0;
    chk("idle_rvalid_instret", bus.instret, exp_cnt);
    send(mk(2'b00, 3'b000, 5'd2, 1'b1, 32'h0BAD_F00D, 32'h0, 32'h0, 0, 1'b0, 1'b1, 32'h0BAD_F00D));
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);

    // Reset in the middle of a load wait drops the load.
    bus.in_valid = 1'b1; bus.in_wb_sel = 2'b01; bus.in_funct3 = 3'b010;
    bus.in_rd = 5'd3; bus.in_reg_write = 1'b1; bus.in_alu_result = 32'h0000_7000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("rst_wait_ready_low", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    q.delete();
    exp_cnt = 64'd0;
    #1;
    chk("rst_async_ready", bus.in_ready, 1'b1);
    chk("rst_async_instret", bus.instret, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.dmem_rdata  = 32'h1111_2222;
    bus.dmem_rvalid = 1'b1;
    @(posedge clk); #1;
    bus.dmem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_instret", bus.instret, 64'd0);
    chk("post_rst_ready", bus.in_ready, 1'b1);
    chk("post_rst_we", bus.rf_we, 1'b0);

    // Stage still works after reset.
    send(mk(2'b00, 3'b000, 5'd4, 1'b1, 32'h0000_0042, 32'h0, 32'h0, 0, 1'b0, 1'b1, 32'h0000_0042));
    repeat (2) @(posedge clk);
    #1;
    chk("final_queue_drained", q.size(), 0);
    chk("final_instret", bus.instret, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the RISC-V pipeline. It accepts one retiring instruction per handshake from the memory stage and selects the result: ALU result, aligned and extended load data, or PC+4. It then drives the register file write port (`we`/`rd`/`wd`) from registered outputs, exposes the same pending write as a decode-stage forwarding path, and counts retired instructions. Loads stall the stage until the data-memory read response arrives.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.
- `CNT_W`, 64, width of the retired-instruction counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  memory stage presents an instruction.
- `in_ready`  out  1  stage can accept; equals (state == IDLE).
- `in_reg_write`  in  1  instruction writes `in_rd`.
- `in_rd`  in  5  destination register.
- `in_wb_sel`  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 reserved (treated as 00).
- `in_alu_result`  in  32  ALU result; also the load address.
- `in_pc_plus4`  in  32  link value.
- `in_funct3`  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `dmem_rvalid`  in  1  load response valid.
- `dmem_rdata`  in  32  load response word, naturally aligned, little-endian.
- `rf_we`, `rf_rd` [5], `rf_wd` [32]  out  register file write port; all registered.
- `fwd_valid`, `fwd_rd` [5], `fwd_data` [32]  out  bypass; identical to `rf_we`/`rf_rd`/`rf_wd`.
- `ld_err`  out  1  one-cycle pulse: illegal funct3 or misaligned load.
- `instret`  out  `CNT_W`  retired-instruction count.

## Operation
- States: IDLE, WAIT_LD.
- Accept occurs when `in_valid && in_ready`.
- Accept, `in_wb_sel` != 01: on the next edge, register `rf_we = in_reg_write && (in_rd != 0)`, `rf_rd = in_rd`, and `rf_wd` = ALU result or PC+4. The state stays IDLE.
- Accept, load: check legality using `in_alu_result[1:0]`.
  - Illegal funct3 (011, 110, 111), LH/LHU with offset 1 or 3, or LW with offset != 0: pulse `ld_err`, leave `rf_we` = 0, do not increment `instret`, stay IDLE.
  - Otherwise: latch `rd`, `reg_write`, funct3, and offset, then go to WAIT_LD.
- WAIT_LD: `dmem_rvalid` is ignored until it is sampled high. On that edge, register the extracted data and `rf_we`, then return to IDLE.
- Extraction: byte = `rdata[8*off +: 8]`; half = `rdata[16*off[1] +: 16]`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- `dmem_rvalid` in IDLE is ignored.
- `rf_we` is a single-cycle pulse. It is 0 on any cycle without a new completion.
- `rf_rd` and `rf_wd` hold their last values when `rf_we` = 0.
- `instret` increments by 1 on the same edge that registers a completion, including rd = 0 and `in_reg_write` = 0. It does not increment for an `ld_err` instruction. It wraps modulo 2^`CNT_W`.

## Timing
- Reset values: state IDLE, `in_ready` 1, `rf_we` 0, `rf_rd` 0, `rf_wd` 0, `fwd_*` 0, `ld_err` 0, `instret` 0.
- Reset asserted mid-WAIT_LD drops the pending load: no write and no count. The state is IDLE as soon as `rst_n` falls.
- Non-load latency: 1 cycle from accept to `rf_we`. Throughput is one per cycle, back-to-back.
- Load latency: the response edge plus 1.
  - The earliest `dmem_rvalid` is sampled the cycle after accept, giving a minimum of 2 cycles from accept to `rf_we`.
  - `in_ready` is 0 throughout WAIT_LD.
  - `in_ready` is 1 in the cycle `rf_we` pulses, so a new accept can overlap the load write.
- Forwarding: `fwd_*` is valid in the same cycle the register file sees the write. Decode must prefer `fwd_data` when `fwd_valid && fwd_rd == rs`, because the register file updates only at the end of that cycle.
- `ld_err` is asserted 1 cycle after the offending accept.
- No combinational path from any input to any output except to `in_ready`, which depends only on state.

## Test plan
- Reset then ALU op: rd = 5, ALU = 0x0000_1234 → next cycle `rf_we` = 1, `rf_rd` = 5, `rf_wd` = 0x0000_1234, `instret` = 1. Following cycle `rf_we` = 0.
- LB with addr offset 3, `dmem_rdata` = 0x80FF_0102 arriving 3 cycles after accept → `in_ready` low for 3 cycles, then `rf_wd` = 0xFFFF_FF80.
- LHU offset 2 with data 0x8001_0000 → 0x0000_8001. LH offset 2 with the same data → 0xFFFF_8001. LW offset 0 with 0xDEAD_BEEF → 0xDEAD_BEEF.
- LW offset 2 → `ld_err` pulse, `rf_we` = 0, `instret` unchanged, state IDLE. funct3 = 110 → same response.
- JAL-type: `in_wb_sel` = 10, PC+4 = 0x100, rd = 0 → `rf_we` = 0, `instret` increments. Back-to-back with an ALU write to rd = 1 in the next cycle → writes on consecutive cycles.
- `rst_n` low during WAIT_LD, then `dmem_rvalid` → no write, `instret` = 0, `in_ready` = 1.
